load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencer between the pipeline MEM stage and `DataMemoryManager`. It accepts one load/store request at a time over a valid/ready handshake and drives the memory-manager port (`address`, `data`, `wren`, `byte_mode`). It waits out the synchronous read latency, then returns sign- or zero-extended load data. Misaligned word accesses and accesses to unpopulated sections are faulted without touching memory.

## Interface
- `READ_LAT`, default 1: cycles from address presentation to valid `mem_data_i`, range 1–4.
- `POPULATED`, default 4'b0001: bit n set means section n (`address[19:18]==n`) exists.
- `CLK`  in  1  system clock, rising edge.
- `RST_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  unit can accept a request.
- `req_write_i`  in  1  1 = store, 0 = load.
- `req_byte_i`  in  1  1 = byte access, 0 = word access.
- `req_signed_i`  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- `req_address_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data; byte stores use bits [7:0].
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_data_o`  out  32  load result; 0 for stores and faults.
- `rsp_fault_o`  out  1  qualifies `rsp_valid_o`; set for misaligned or unpopulated access.
- `mem_address_o`  out  32  to memory manager `address_i`.
- `mem_data_o`  out  32  to memory manager `data_i`.
- `mem_wren_o`  out  1  to memory manager `wren_i`.
- `mem_byte_mode_o`  out  32  to memory manager `byte_mode_i`; 32'd1 = byte, 32'd0 = word.
- `mem_data_i`  in  32  from memory manager `data_o`; for byte reads the byte is in bits [7:0].

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP. Request fields are captured into registers on acceptance (`req_valid_i && req_ready_o` in IDLE).
- Fault check at acceptance:
  - misaligned = `!req_byte_i && address[1:0]!=0`;
  - unpopulated = `!POPULATED[address[19:18]]`;
  - either condition: IDLE→RESP directly with fault=1, data=0, no memory activity.
- IDLE→ACCESS on a good request.
- ACCESS, one cycle: drive `mem_address_o`, `mem_data_o`, and `mem_byte_mode_o`.
  - Store: `mem_wren_o`=1 for this cycle only, then go to RESP.
  - Load: `mem_wren_o`=0, go to WAIT.
- WAIT, `READ_LAT` cycles: down-counter loaded with `READ_LAT-1` on entry. Address and byte mode stay stable. When the counter is 0, capture `mem_data_i` and go to RESP.
- Load extension:
  - word: data unchanged;
  - byte signed: `{{24{d[7]}},d[7:0]}`;
  - byte unsigned: `{24'b0,d[7:0]}`.
- RESP, one cycle: `rsp_valid_o`=1 with data and fault, then go to IDLE.
- `req_ready_o` is registered and is 1 only while in IDLE. A request presented outside IDLE is not accepted and must be held by the upstream stage.
- Outside ACCESS/WAIT, `mem_wren_o`=0. `mem_address_o`, `mem_data_o`, and `mem_byte_mode_o` hold their last value.

## Timing
- Reset values (async on `RST_n` low): state IDLE, `req_ready_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_fault_o`=0, all `mem_*_o`=0. `req_ready_o` rises on the first edge after `RST_n` deasserts.
- Store accepted at edge t0: `mem_wren_o` high in cycle t0+1, `rsp_valid_o` in t0+2, `req_ready_o` high again in t0+3.
- Load accepted at t0: address presented in t0+1, data sampled at end of cycle t0+1+READ_LAT, `rsp_valid_o` in t0+2+READ_LAT.
- Fault accepted at t0: `rsp_valid_o` with fault in t0+1, ready again in t0+2.
- Throughput: at most one request in flight; no back-to-back acceptance.
- Reset mid-operation: `mem_wren_o` drops immediately (async), any pending response is discarded, and no `rsp_valid_o` is emitted after release.
- Byte access with any `address[1:0]` is legal and never faults on alignment.

## Structure
- Shared package `lsu_pkg`: state enum `lsu_state_t`, constants `BYTE_MODE_WORD`=32'd0 and `BYTE_MODE_BYTE`=32'd1, section-field bounds [19:18].
- Sub-module `load_extend`: combinational extension of the 32-bit read data by byte/signed flags, unit-tested separately.
- Top level: FSM, WAIT counter, and request/response registers.

## Test plan
- Word store 0x0000_0010 ← 0xDEADBEEF, then word load of the same address → `mem_wren_o` pulses exactly once with byte mode 0; load response 0xDEADBEEF at t0+2+READ_LAT.
- Byte store 0x0000_0013 ← 0x80, then signed byte load → 0xFFFF_FF80; unsigned byte load → 0x0000_0080.
- Word load at 0x0000_0006 → `rsp_fault_o`=1 with data 0 at t0+1; `mem_wren_o` never asserted, `mem_address_o` unchanged.
- Store to 0x0004_0000 with POPULATED=4'b0001 → fault, no wren; the same address with POPULATED=4'b0011 succeeds.
- READ_LAT=3, load issued, `req_valid_i` held high with a second request → second request accepted only after RESP; first response at t0+5.
- `RST_n` pulled low during a store's ACCESS cycle → `mem_wren_o` falls immediately, no response after release, `req_ready_o`=1 one edge after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
package lsu_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SECTION_HI = 19;
    localparam int unsigned SECTION_LO = 18;
    localparam int unsigned SECTION_W  = SECTION_HI - SECTION_LO + 1;
    localparam int unsigned CNT_W      = 2;

    localparam logic [DATA_W-1:0] BYTE_MODE_WORD = 32'd0;
    localparam logic [DATA_W-1:0] BYTE_MODE_BYTE = 32'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Request payload as presented by the MEM stage.
    typedef struct packed {
        logic              is_write;
        logic              is_byte;
        logic              is_signed;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
    } lsu_req_t;

    // Memory section selected by an address.
    function automatic logic [SECTION_W-1:0] section_of(input logic [ADDR_W-1:0] addr);
        return addr[SECTION_HI:SECTION_LO];
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of raw read data for byte loads; word loads pass through.
module load_extend
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] raw_data,
    input  logic              is_byte,
    input  logic              is_signed,
    output logic [DATA_W-1:0] ext_data_c
);

    // Select word, sign-extended byte or zero-extended byte.
    always_comb begin
        ext_data_c = raw_data;
        if (is_byte) begin
            if (is_signed) begin
                ext_data_c = {{24{raw_data[7]}}, raw_data[7:0]};
            end else begin
                ext_data_c = {24'b0, raw_data[7:0]};
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the MEM stage and the data memory manager.
// One request in flight; misaligned words and unpopulated sections are
// answered with a fault without any memory activity.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned READ_LAT  = 1,
    parameter logic [3:0]  POPULATED = 4'b0001
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic              req_byte_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_address_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_fault_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_wren_o,
    output logic [DATA_W-1:0] mem_byte_mode_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    lsu_state_t       state;
    lsu_req_t         req_c;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_write_q;
    logic             is_byte_q;
    logic             is_signed_q;
    logic             accept_c;
    logic             misaligned_c;
    logic             unpopulated_c;
    logic [DATA_W-1:0] ext_data_c;

    // Bundle the incoming request fields.
    assign req_c = '{
        is_write:  req_write_i,
        is_byte:   req_byte_i,
        is_signed: req_signed_i,
        address:   req_address_i,
        wdata:     req_wdata_i
    };

    // Acceptance and fault classification of the presented request.
    assign accept_c      = (state == IDLE) && req_valid_i && req_ready_o;
    assign misaligned_c  = !req_c.is_byte && (req_c.address[1:0] != 2'b00);
    assign unpopulated_c = !POPULATED[section_of(req_c.address)];

    load_extend u_load_extend (
        .raw_data   (mem_data_i),
        .is_byte    (is_byte_q),
        .is_signed  (is_signed_q),
        .ext_data_c (ext_data_c)
    );

    // Sequencer FSM with the read-latency counter and all registered outputs.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            is_write_q      <= 1'b0;
            is_byte_q       <= 1'b0;
            is_signed_q     <= 1'b0;
            req_ready_o     <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_data_o      <= '0;
            rsp_fault_o     <= 1'b0;
            mem_address_o   <= '0;
            mem_data_o      <= '0;
            mem_wren_o      <= 1'b0;
            mem_byte_mode_o <= BYTE_MODE_WORD;
        end else begin
            mem_wren_o  <= 1'b0;
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (accept_c) begin
                        req_ready_o <= 1'b0;
                        is_write_q  <= req_c.is_write;
                        is_byte_q   <= req_c.is_byte;
                        is_signed_q <= req_c.is_signed;
                        if (misaligned_c || unpopulated_c) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_fault_o <= 1'b1;
                            rsp_data_o  <= '0;
                        end else begin
                            state           <= ACCESS;
                            mem_address_o   <= req_c.address;
                            mem_data_o      <= req_c.wdata;
                            mem_byte_mode_o <= req_c.is_byte ? BYTE_MODE_BYTE : BYTE_MODE_WORD;
                            mem_wren_o      <= req_c.is_write;
                        end
                    end
                end
                ACCESS: begin
                    if (is_write_q) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_fault_o <= 1'b0;
                        rsp_data_o  <= '0;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= CNT_W'(READ_LAT - 1);
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_fault_o <= 1'b0;
                        rsp_data_o  <= ext_data_c;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    rsp_data_o  <= '0;
                    rsp_fault_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (READ_LAT=1/POPULATED=0001 and
// READ_LAT=3/POPULATED=0011) with a behavioural memory manager each.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        req_valid   [NI];
    logic        req_write   [NI];
    logic        req_byte    [NI];
    logic        req_signed  [NI];
    logic [31:0] req_address [NI];
    logic [31:0] req_wdata   [NI];
    logic        req_ready   [NI];
    logic        rsp_valid   [NI];
    logic [31:0] rsp_data    [NI];
    logic        rsp_fault   [NI];
    logic [31:0] mem_address [NI];
    logic [31:0] mem_dout    [NI];
    logic        mem_wren    [NI];
    logic [31:0] mem_bmode   [NI];
    logic [31:0] mem_rdata   [NI];

    bit [7:0]  mem     [NI][1024];
    bit [7:0]  ref_mem [NI][1024];
    bit [31:0] pipe    [NI][4];
    logic [31:0] last_addr [NI];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic int rl_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [3:0] pop_of(input int g);
        return (g == 0) ? 4'b0001 : 4'b0011;
    endfunction

    function automatic logic [9:0] midx(input logic [31:0] a);
        return {a[19:18], a[7:0]};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        load_store_unit #(
            .READ_LAT  ((g == 0) ? 1 : 3),
            .POPULATED ((g == 0) ? 4'b0001 : 4'b0011)
        ) dut (
            .CLK             (clk),
            .RST_n           (rst_n),
            .req_valid_i     (req_valid[g]),
            .req_ready_o     (req_ready[g]),
            .req_write_i     (req_write[g]),
            .req_byte_i      (req_byte[g]),
            .req_signed_i    (req_signed[g]),
            .req_address_i   (req_address[g]),
            .req_wdata_i     (req_wdata[g]),
            .rsp_valid_o     (rsp_valid[g]),
            .rsp_data_o      (rsp_data[g]),
            .rsp_fault_o     (rsp_fault[g]),
            .mem_address_o   (mem_address[g]),
            .mem_data_o      (mem_dout[g]),
            .mem_wren_o      (mem_wren[g]),
            .mem_byte_mode_o (mem_bmode[g]),
            .mem_data_i      (mem_rdata[g])
        );
    end

    // Memory manager model: synchronous read with a READ_LAT-deep pipe, byte or word writes.
    always @(posedge clk) begin
        logic [9:0]  ix;
        logic [31:0] rd;
        for (int g = 0; g < NI; g++) begin
            ix = midx(mem_address[g]);
            if (mem_bmode[g][0]) rd = {24'hA5A5A5, mem[g][ix]};
            else rd = {mem[g][ix + 10'd3], mem[g][ix + 10'd2], mem[g][ix + 10'd1], mem[g][ix]};
            pipe[g][0] <= rd;
            for (int k = 1; k < 4; k++) pipe[g][k] <= pipe[g][k-1];
            if (mem_wren[g]) begin
                if (mem_bmode[g][0]) begin
                    mem[g][ix] <= mem_dout[g][7:0];
                end else begin
                    mem[g][ix]         <= mem_dout[g][7:0];
                    mem[g][ix + 10'd1] <= mem_dout[g][15:8];
                    mem[g][ix + 10'd2] <= mem_dout[g][23:16];
                    mem[g][ix + 10'd3] <= mem_dout[g][31:24];
                end
            end
        end
    end

    always_comb begin
        for (int g = 0; g < NI; g++) mem_rdata[g] = pipe[g][rl_of(g) - 1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: fault, response latency and load data from the rules directly.
    task automatic model(input int g, input logic w, input logic b, input logic s,
                         input logic [31:0] addr, output logic f, output int lat,
                         output logic [31:0] d);
        logic [3:0] pm;
        int unsigned ix;
        int unsigned word;
        int bv;
        pm  = pop_of(g);
        ix  = int'(midx(addr));
        f   = (!b && addr[1:0] != 2'b00) || !pm[addr[19:18]];
        lat = f ? 1 : (w ? 2 : 2 + rl_of(g));
        d   = 32'd0;
        if (!f && !w) begin
            if (b) begin
                bv = int'(ref_mem[g][ix]);
                if (s && bv >= 128) bv = bv - 256;
                d = 32'(bv);
            end else begin
                word = 0;
                for (int k = 3; k >= 0; k--) word = word * 256 + int'(ref_mem[g][(ix + k) % 1024]);
                d = 32'(word);
            end
        end
    endtask

    task automatic ref_store(input int g, input logic b, input logic [31:0] addr, input logic [31:0] wd);
        int unsigned ix;
        ix = int'(midx(addr));
        ref_mem[g][ix] = wd[7:0];
        if (!b) begin
            ref_mem[g][(ix + 1) % 1024] = wd[15:8];
            ref_mem[g][(ix + 2) % 1024] = wd[23:16];
            ref_mem[g][(ix + 3) % 1024] = wd[31:24];
        end
    endtask

    task automatic wait_ready(input int g);
        int waited = 0;
        while (!req_ready[g] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", 32'(req_ready[g]), 32'd1);
    endtask

    // One full transaction with timing and response checks; called at a negedge.
    task automatic run_txn(input int g, input logic w, input logic b, input logic s,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic ef, input int el, input logic [31:0] ed);
        int first = 0;
        int pulses = 0;
        int wrens = 0;
        logic [31:0] got_d = 32'd0;
        logic got_f = 1'b0;
        logic early_ready = 1'b0;
        logic mf;
        int ml;
        logic [31:0] md;
        wait_ready(g);
        req_write[g] = w; req_byte[g] = b; req_signed[g] = s;
        req_address[g] = addr; req_wdata[g] = wd; req_valid[g] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= el + 1; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_valid[g] = 1'b0;
                if (!ef) begin
                    chk("mem_address", mem_address[g], addr);
                    chk("mem_byte_mode", mem_bmode[g], b ? 32'd1 : 32'd0);
                    if (w) chk("mem_data", b ? {24'h0, mem_dout[g][7:0]} : mem_dout[g],
                               b ? {24'h0, wd[7:0]} : wd);
                end
            end
            if (mem_wren[g]) wrens++;
            if (rsp_valid[g]) begin
                pulses++;
                if (first == 0) begin
                    first = n;
                    got_d = rsp_data[g];
                    got_f = rsp_fault[g];
                end
            end
            if (n <= el && req_ready[g]) early_ready = 1'b1;
        end
        chk("rsp_latency", 32'(first), 32'(el));
        chk("rsp_pulses", 32'(pulses), 32'd1);
        chk("rsp_data", got_d, ed);
        chk("rsp_fault", 32'(got_f), 32'(ef));
        chk("wren_pulses", 32'(wrens), (!ef && w) ? 32'd1 : 32'd0);
        chk("busy_not_ready", 32'(early_ready), 32'd0);
        chk("ready_after_resp", 32'(req_ready[g]), 32'd1);
        if (ef) chk("mem_address_held", mem_address[g], last_addr[g]);
        model(g, w, b, s, addr, mf, ml, md);
        if (!mf) last_addr[g] = addr;
        if (!mf && w) ref_store(g, b, addr, wd);
    endtask

    typedef struct {
        int          g;
        logic        w;
        logic        b;
        logic        s;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        f;
        int          lat;
        logic [31:0] d;
    } vec_t;

    function automatic vec_t mk(input int g, input logic w, input logic b, input logic s,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic f, input int lat, input logic [31:0] d);
        vec_t v;
        v.g = g; v.w = w; v.b = b; v.s = s; v.addr = addr; v.wd = wd;
        v.f = f; v.lat = lat; v.d = d;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        int   first_rsp;
        int   first_rdy;
        int   wrens;
        int   pulses;
        logic [31:0] d;

        for (int g = 0; g < NI; g++) begin
            req_valid[g] = 1'b0; req_write[g] = 1'b0; req_byte[g] = 1'b0;
            req_signed[g] = 1'b0; req_address[g] = 32'd0; req_wdata[g] = 32'd0;
            last_addr[g] = 32'd0;
        end

        // Reset values.
        #3;
        for (int g = 0; g < NI; g++) begin
            chk("reset_ready", 32'(req_ready[g]), 32'd0);
            chk("reset_rsp_valid", 32'(rsp_valid[g]), 32'd0);
            chk("reset_rsp_data", rsp_data[g], 32'd0);
            chk("reset_rsp_fault", 32'(rsp_fault[g]), 32'd0);
            chk("reset_mem_address", mem_address[g], 32'd0);
            chk("reset_mem_data", mem_dout[g], 32'd0);
            chk("reset_mem_wren", 32'(mem_wren[g]), 32'd0);
            chk("reset_mem_byte_mode", mem_bmode[g], 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++) chk("ready_after_reset", 32'(req_ready[g]), 32'd1);

        // Directed vectors: {inst, write, byte, signed, addr, wdata, fault, latency, data}.
        vecs.push_back(mk(0, 1, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 2, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0000_0010, 32'h0,         0, 3, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0000_0013, 32'h1234_5680, 0, 2, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h0000_0013, 32'h0,         0, 3, 32'hFFFF_FF80));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0000_0013, 32'h0,         0, 3, 32'h0000_0080));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0000_0010, 32'h0,         0, 3, 32'h80AD_BEEF));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0000_0006, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0004_0000, 32'h1111_1111, 1, 1, 32'h0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0004_0000, 32'hCAFE_F00D, 0, 2, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0004_0000, 32'h0,         0, 5, 32'hCAFE_F00D));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0004_0002, 32'h0,         0, 5, 32'h0000_00FE));
        vecs.push_back(mk(1, 0, 1, 1, 32'h0004_0001, 32'h0,         0, 5, 32'hFFFF_FFF0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h000C_0000, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0000_0005, 32'hFFFF_FF7F, 0, 2, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h0000_0005, 32'h0,         0, 3, 32'h0000_007F));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0008_0002, 32'h2222_2222, 1, 1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0004_0003, 32'h0,         1, 1, 32'h0));
        foreach (vecs[i]) begin
            run_txn(vecs[i].g, vecs[i].w, vecs[i].b, vecs[i].s, vecs[i].addr, vecs[i].wd,
                    vecs[i].f, vecs[i].lat, vecs[i].d);
        end

        // Second request held during a READ_LAT=3 load is taken only after the response.
        wait_ready(1);
        req_write[1] = 1'b0; req_byte[1] = 1'b0; req_signed[1] = 1'b0;
        req_address[1] = 32'h0004_0000; req_wdata[1] = 32'h0; req_valid[1] = 1'b1;
        @(posedge clk);
        first_rsp = 0; first_rdy = 0; wrens = 0; d = 32'h0;
        for (int n = 1; n <= 12 && first_rdy == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_write[1] = 1'b1; req_address[1] = 32'h0004_0004; req_wdata[1] = 32'h55AA_55AA;
            end
            if (mem_wren[1]) wrens++;
            if (rsp_valid[1] && first_rsp == 0) begin
                first_rsp = n;
                d = rsp_data[1];
            end
            if (req_ready[1]) first_rdy = n;
        end
        chk("b2b_first_rsp_cycle", 32'(first_rsp), 32'd5);
        chk("b2b_first_rsp_data", d, 32'hCAFE_F00D);
        chk("b2b_ready_cycle", 32'(first_rdy), 32'd6);
        chk("b2b_no_early_wren", 32'(wrens), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_second_wren", 32'(mem_wren[1]), 32'd1);
        chk("b2b_second_addr", mem_address[1], 32'h0004_0004);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("b2b_second_rsp", 32'(rsp_valid[1]), 32'd1);
        chk("b2b_second_fault", 32'(rsp_fault[1]), 32'd0);
        @(negedge clk);
        chk("b2b_ready_again", 32'(req_ready[1]), 32'd1);
        ref_store(1, 1'b0, 32'h0004_0004, 32'h55AA_55AA);
        last_addr[1] = 32'h0004_0004;

        // Reset asserted during a store's ACCESS cycle.
        wait_ready(0);
        req_write[0] = 1'b1; req_byte[0] = 1'b0; req_signed[0] = 1'b0;
        req_address[0] = 32'h0000_0020; req_wdata[0] = 32'h1234_5678; req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wren_before", 32'(mem_wren[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        req_valid[0] = 1'b0;
        #1;
        chk("rst_wren_async_drop", 32'(mem_wren[0]), 32'd0);
        chk("rst_ready_low", 32'(req_ready[0]), 32'd0);
        chk("rst_mem_address", mem_address[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (rsp_valid[0]) pulses++;
            if (n == 1) chk("rst_ready_one_edge", 32'(req_ready[0]), 32'd1);
        end
        chk("rst_no_response", 32'(pulses), 32'd0);
        last_addr[0] = 32'd0;
        last_addr[1] = 32'd0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            int g;
            logic w, b, s, mf;
            logic [1:0] sec;
            logic [7:0] off;
            logic [31:0] addr, wd, md;
            int ml;
            g   = int'($urandom_range(1, 0));
            w   = 1'($urandom_range(1, 0));
            b   = 1'($urandom_range(1, 0));
            s   = 1'($urandom_range(1, 0));
            sec = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 0))
                                              : ((g == 1) ? 2'($urandom_range(1, 0)) : 2'd0);
            off = 8'($urandom_range(255, 0));
            if (!b && $urandom_range(3, 0) != 0) off[1:0] = 2'b00;
            addr = {12'h0, sec, 10'h0, off};
            wd   = $urandom;
            model(g, w, b, s, addr, mf, ml, md);
            run_txn(g, w, b, s, addr, wd, mf, ml, md);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
